// File: rtl/mips_run_ctrl_if.sv
// Control/status bundle between the run sequencer and its host plus the datapath PC.
interface mips_run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             step;
  logic             halt_req;
  logic [31:0]      cpu_pc;
  logic             cpu_en;
  logic             cpu_rst;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [2:0]       dbg_state;

  // start/step are one-cycle request pulses acted on at the next edge and
  // halt_req is a level; there is no ready, the host observes busy/done.
  modport master (
    output start, step, halt_req, cpu_pc,
    input  cpu_en, cpu_rst, busy, done, timeout, cycle_count, dbg_state
  );

  modport slave (
    input  start, step, halt_req, cpu_pc,
    output cpu_en, cpu_rst, busy, done, timeout, cycle_count, dbg_state
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run/debug sequencer for the single-cycle MIPS datapath: owns its reset and
// clock enable, counts executed cycles and stops on end PC, stall or timeout.
module mips_run_ctrl #(
  parameter logic [31:0] END_PC      = 32'h0000_00F8,
  parameter int          STALL_LIMIT = 4,
  parameter int          MAX_CYCLES  = 1024,
  parameter int          RST_CYCLES  = 2,
  parameter int          CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  mips_run_ctrl_if.slave    bus
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int SC_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET_CPU = 3'd1,
    S_RUN       = 3'd2,
    S_PAUSE     = 3'd3,
    S_STEP      = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             timeout_q, timeout_d;
  logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [31:0]      prev_pc_q, prev_pc_d;
  logic             prev_vld_q, prev_vld_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic end_hit, budget_hit, executing, cpu_en_c, same_pc, stall;

  assign end_hit    = (bus.cpu_pc == END_PC);
  assign budget_hit = (cycle_count_q == CNT_W'(MAX_CYCLES));
  assign executing  = (state_q == S_RUN) || (state_q == S_STEP);
  // halt_req only gates RUN; a STEP already granted always completes.
  assign cpu_en_c   = executing && !end_hit && !budget_hit &&
                      !((state_q == S_RUN) && bus.halt_req);
  assign same_pc    = prev_vld_q && (bus.cpu_pc == prev_pc_q);
  assign stall      = cpu_en_c && same_pc && (stall_cnt_q == SC_W'(STALL_LIMIT - 1));

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    prev_pc_d     = prev_pc_q;
    prev_vld_d    = prev_vld_q;
    stall_cnt_d   = (cpu_en_c && same_pc) ? stall_cnt_q + SC_W'(1) : '0;

    if (cpu_en_c) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
      prev_pc_d     = bus.cpu_pc;
      prev_vld_d    = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d       = S_RESET_CPU;
          rst_cnt_d     = '0;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
          stall_cnt_d   = '0;
          prev_vld_d    = 1'b0;
        end
      end
      S_RESET_CPU: begin
        prev_vld_d = 1'b0;
        if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = S_RUN;
        else                                    rst_cnt_d = rst_cnt_q + RC_W'(1);
      end
      S_RUN, S_STEP: begin
        if (end_hit) begin
          state_d = S_DONE;
        end else if (budget_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (stall) begin
          state_d = S_DONE;
        end else if (state_q == S_STEP || bus.halt_req) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (!bus.halt_req) begin
          if (bus.start)     state_d = S_RUN;
          else if (bus.step) state_d = S_STEP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cpu_rst_d = (state_d == S_IDLE) || (state_d == S_RESET_CPU);
    busy_d    = (state_d == S_RESET_CPU) || (state_d == S_RUN) ||
                (state_d == S_PAUSE) || (state_d == S_STEP);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      stall_cnt_q   <= '0;
      prev_pc_q     <= '0;
      prev_vld_q    <= 1'b0;
      cpu_rst_q     <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      prev_pc_q     <= prev_pc_d;
      prev_vld_q    <= prev_vld_d;
      cpu_rst_q     <= cpu_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.cpu_en      = cpu_en_c;
  assign bus.cpu_rst     = cpu_rst_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: a toy datapath walks scripted programs while runs
// are checked against trace-level expectations (end PC, self-loop, timeout).
module tb_mips_run_ctrl;
  localparam logic [31:0] END_PC = 32'h0000_00F8;
  localparam int STALL_LIMIT = 4;
  localparam int MAX_CYCLES  = 1024;
  localparam int RST_CYCLES  = 2;
  localparam int CNT_W       = 16;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_RSTC = 3'd1, ST_RUN = 3'd2,
                         ST_PAUSE = 3'd3, ST_STEP = 3'd4, ST_DONE = 3'd5;

  typedef struct {
    int          kind;    // 0 straight line to END_PC, 1 branch-to-self, 2 two-instr loop
    int          addr;
    int          halt_at; // -1: no pause
    int          nsteps;
    bit          noise;   // stray start pulse while running
    int          exp_count;
    bit          exp_timeout;
    logic [31:0] exp_pc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  mips_run_ctrl_if #(.CNT_W(CNT_W)) bus();

  mips_run_ctrl #(
    .END_PC(END_PC), .STALL_LIMIT(STALL_LIMIT), .MAX_CYCLES(MAX_CYCLES),
    .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Toy datapath: PC advances only on enabled edges, cleared by cpu_rst.
  int          prog_kind = 0;
  int          loop_addr = 0;
  logic [31:0] pc = 32'h0;
  assign bus.cpu_pc = pc;

  function automatic logic [31:0] next_pc(logic [31:0] p);
    if (prog_kind == 1 && p == 32'(loop_addr))     return p;
    if (prog_kind == 2 && p == 32'(loop_addr + 4)) return 32'(loop_addr);
    return p + 32'd4;
  endfunction

  always @(posedge clk) begin
    if (bus.cpu_rst)     pc <= 32'h0;
    else if (bus.cpu_en) pc <= next_pc(pc);
  end

  // Reference: PC after i executed instructions, read off the program trace.
  function automatic logic [31:0] pc_after(int kind, int addr, int i);
    int k;
    k = addr / 4;
    if (kind == 0) return 32'(4 * i);
    if (kind == 1) return 32'(4 * ((i < k) ? i : k));
    if (i <= k + 1) return 32'(4 * i);
    return 32'(addr + 4 * ((i - k) % 2));
  endfunction

  function automatic vec_t model(vec_t v);
    vec_t r;
    r = v;
    case (v.kind)
      0: begin r.exp_count = int'(END_PC) / 4;  r.exp_timeout = 0; r.exp_pc = END_PC; end
      1: begin r.exp_count = v.addr / 4 + 1 + STALL_LIMIT; r.exp_timeout = 0;
               r.exp_pc = 32'(v.addr); end
      default: begin r.exp_count = MAX_CYCLES; r.exp_timeout = 1;
               r.exp_pc = pc_after(2, v.addr, MAX_CYCLES); end
    endcase
    return r;
  endfunction

  function automatic vec_t mk(int kind, int addr, int halt_at, int nsteps, bit noise,
                              int cnt, bit to, logic [31:0] epc);
    vec_t r;
    r.kind = kind; r.addr = addr; r.halt_at = halt_at; r.nsteps = nsteps;
    r.noise = noise; r.exp_count = cnt; r.exp_timeout = to; r.exp_pc = epc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pause_seq(input vec_t v);
    int c;
    c = v.halt_at;
    bus.halt_req = 1'b1;
    #1 chk("halt_gates_en", bus.cpu_en, 1'b0);
    @(negedge clk);
    chk("pause_state", bus.dbg_state, ST_PAUSE);
    chk("pause_count", bus.cycle_count, 32'(c));
    chk("pause_busy", bus.busy, 1'b1);
    chk("pause_rst", bus.cpu_rst, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("halt_beats_start", bus.dbg_state, ST_PAUSE);
    bus.halt_req = 1'b0;
    for (int i = 0; i < v.nsteps; i++) begin
      bus.step = 1'b1;
      @(negedge clk);
      bus.step = 1'b0;
      chk("step_state", bus.dbg_state, ST_STEP);
      chk("step_en", bus.cpu_en, 1'b1);
      @(negedge clk);
      chk("step_back", bus.dbg_state, ST_PAUSE);
    end
    chk("steps_count", bus.cycle_count, 32'(c + v.nsteps));
    chk("steps_pc", pc, pc_after(v.kind, v.addr, c + v.nsteps));
    bus.step = 1'b1; bus.halt_req = 1'b1;
    @(negedge clk);
    bus.step = 1'b0; bus.halt_req = 1'b0;
    chk("halt_beats_step", bus.dbg_state, ST_PAUSE);
    chk("halt_step_count", bus.cycle_count, 32'(c + v.nsteps));
    bus.start = 1'b1; bus.step = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.step = 1'b0;
    chk("resume_run", bus.dbg_state, ST_RUN);
  endtask

  task automatic run_vec(input vec_t v);
    int  cyc;
    bit  paused;
    prog_kind = v.kind;
    loop_addr = v.addr;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rstc_state", bus.dbg_state, ST_RSTC);
    chk("rstc_cpu_rst", bus.cpu_rst, 1'b1);
    chk("rstc_count", bus.cycle_count, 32'd0);
    chk("rstc_timeout", bus.timeout, 1'b0);
    chk("rstc_done", bus.done, 1'b0);
    for (int i = 1; i < RST_CYCLES; i++) begin
      @(negedge clk);
      chk("rstc_hold", bus.cpu_rst, 1'b1);
    end
    @(negedge clk);
    chk("run_cpu_rst", bus.cpu_rst, 1'b0);
    chk("run_state", bus.dbg_state, ST_RUN);
    paused = 0;
    cyc = 0;
    while (bus.dbg_state != ST_DONE && cyc < 4000) begin
      if (v.noise && bus.dbg_state == ST_RUN && bus.cycle_count == 2) begin
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_ignored", bus.dbg_state, ST_RUN);
      end else if (!paused && v.halt_at >= 0 && bus.cycle_count == CNT_W'(v.halt_at)) begin
        pause_seq(v);
        paused = 1;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    if (cyc >= 4000) begin
      n_vec++; n_err++;
      $display("FAIL run_budget: no done after %0d cycles, want done", cyc);
    end
    chk("done", bus.done, 1'b1);
    chk("done_busy", bus.busy, 1'b0);
    chk("done_count", bus.cycle_count, 32'(v.exp_count));
    chk("done_timeout", bus.timeout, v.exp_timeout);
    chk("done_pc", pc, v.exp_pc);
    chk("done_en", bus.cpu_en, 1'b0);
    chk("done_cpu_rst", bus.cpu_rst, 1'b0);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    chk("step_in_done", bus.dbg_state, ST_DONE);
    chk("done_hold", bus.cycle_count, 32'(v.exp_count));
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    int cyc;
    bus.start = 1'b0; bus.step = 1'b0; bus.halt_req = 1'b0;

    tbl[0] = mk(0, 0,    -1, 0, 0, 62,   0, 32'h0000_00F8);
    tbl[1] = mk(1, 32,   -1, 0, 0, 13,   0, 32'h0000_0020);
    tbl[2] = mk(2, 16,   -1, 0, 0, 1024, 1, 32'h0000_0010);
    tbl[3] = mk(0, 0,    10, 3, 0, 62,   0, 32'h0000_00F8);
    tbl[4] = mk(1, 0,    -1, 0, 0, 5,    0, 32'h0000_0000);
    tbl[5] = mk(1, 244,  -1, 0, 0, 66,   0, 32'h0000_00F4);
    tbl[6] = mk(2, 240,  -1, 0, 1, 1024, 1, 32'h0000_00F0);
    tbl[7] = mk(0, 0,    61, 1, 1, 62,   0, 32'h0000_00F8);

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", bus.dbg_state, ST_IDLE);
    chk("reset_cpu_rst", bus.cpu_rst, 1'b1);
    chk("reset_en", bus.cpu_en, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_count", bus.cycle_count, 32'd0);
    chk("reset_timeout", bus.timeout, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_cpu_rst", bus.cpu_rst, 1'b1);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);
    run_vec(tbl[0]);

    for (int i = 0; i < 10; i++) begin
      rv = mk(int'($urandom_range(0, 2)), 0, -1, 0, 0, 0, 0, 32'h0);
      case (rv.kind)
        0: begin rv.halt_at = int'($urandom_range(5, 55));
                 rv.nsteps = int'($urandom_range(0, 4)); rv.noise = 1'($urandom); end
        1: rv.addr = 4 * int'($urandom_range(0, 61));
        default: begin rv.addr = 4 * int'($urandom_range(0, 60));
                 rv.halt_at = int'($urandom_range(5, 1000));
                 rv.nsteps = int'($urandom_range(0, 4)); rv.noise = 1'($urandom); end
      endcase
      run_vec(model(rv));
    end

    // Asynchronous reset in the middle of a run.
    prog_kind = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.cycle_count != 30 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("pre_abort_state", bus.dbg_state, ST_RUN);
    #2 reset = 1'b0;
    #1;
    chk("abort_state", bus.dbg_state, ST_IDLE);
    chk("abort_cpu_rst", bus.cpu_rst, 1'b1);
    chk("abort_en", bus.cpu_en, 1'b0);
    chk("abort_count", bus.cycle_count, 32'd0);
    chk("abort_busy", bus.busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run_vec(tbl[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
